// File: rtl/adc_if_pkg.sv
// Shared definitions for the ADC serial interface: word width default,
// SPI mode constants and the command writer FSM state type.
package adc_if_pkg;

    localparam int WORD_W_DEF = 8;

    // SPI mode 0: sclk idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } wr_state_e;

endpackage

// File: rtl/adc_cmd_writer_word_fifo.sv
// Synchronous word FIFO with occupancy count; a push on a full FIFO and a
// pop on an empty FIFO are ignored.
module word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_cmd_writer.sv
// Buffered SPI mode-0 command writer toward the ADC. Define
// ADC_WR_LSB_FIRST_EN to serialize words LSB-first instead of MSB-first.
module adc_cmd_writer
    import adc_if_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              sclk,
    output logic              sdo,
    output logic              cs_n,
    output logic              busy,
    output logic              done
);
    localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W = $clog2(WORD_W+1);
    localparam int GC_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [HP_W-1:0] HP_LOAD   = HP_W'(CLK_DIV-1);
    localparam logic [BC_W-1:0] BITS_LAST = BC_W'(WORD_W);
    localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(CS_GAP-1);

`ifdef ADC_WR_LSB_FIRST_EN
    localparam int HEAD = 0;
    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
        return w >> 1;
    endfunction
`else
    localparam int HEAD = WORD_W-1;
    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
        return w << 1;
    endfunction
`endif

    wr_state_e                      state;
    logic                           armed;
    logic [HP_W-1:0]                hp_cnt;
    logic [BC_W-1:0]                bit_cnt;
    logic [GC_W-1:0]                gap_cnt;
    logic [WORD_W-1:0]              shreg;
    logic [WORD_W-1:0]              rd_word;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           tick;
    logic                           last_bit;
    logic                           pop;
    logic                           push;

    assign tick     = (hp_cnt == '0);
    assign last_bit = (bit_cnt == BITS_LAST);
    assign push     = wr_valid && !fifo_full;
    assign wr_ready = !fifo_full;
    assign busy     = (fifo_count != '0) || (state != IDLE) || armed;
    assign pop      = tick && !fifo_empty &&
                      (((state == IDLE) && !armed) || ((state == SHIFT_HI) && last_bit));

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_data),
        .pop   (pop),
        .rdata (rd_word),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // shreg holds the bits not yet placed on sdo, head bit first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            armed   <= 1'b0;
            hp_cnt  <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            sclk    <= SPI_CPOL;
            sdo     <= 1'b0;
            cs_n    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!tick) begin
                hp_cnt <= hp_cnt - 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed) begin
                            armed   <= 1'b0;
                            cs_n    <= 1'b0;
                            sdo     <= shreg[HEAD];
                            shreg   <= advance(shreg);
                            bit_cnt <= BC_W'(1);
                            hp_cnt  <= HP_LOAD;
                            state   <= SETUP;
                        end else if (pop) begin
                            shreg <= rd_word;
                            armed <= 1'b1;
                        end
                    end
                    SETUP: begin
                        hp_cnt <= HP_LOAD;
                        sclk   <= ~SPI_CPOL;
                        state  <= SHIFT_HI;
                    end
                    SHIFT_HI: begin
                        hp_cnt <= HP_LOAD;
                        sclk   <= SPI_CPOL;
                        if (!last_bit) begin
                            sdo     <= shreg[HEAD];
                            shreg   <= advance(shreg);
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= SHIFT_LO;
                        end else if (pop) begin
                            sdo     <= rd_word[HEAD];
                            shreg   <= advance(rd_word);
                            bit_cnt <= BC_W'(1);
                            state   <= SHIFT_LO;
                        end else begin
                            sdo     <= 1'b0;
                            gap_cnt <= '0;
                            state   <= HOLD;
                        end
                    end
                    SHIFT_LO: begin
                        hp_cnt <= HP_LOAD;
                        sclk   <= ~SPI_CPOL;
                        state  <= SHIFT_HI;
                    end
                    HOLD: begin
                        // reload keeps cs_n high for a half-period in IDLE
                        hp_cnt <= HP_LOAD;
                        if (gap_cnt == GAP_LAST) begin
                            cs_n  <= 1'b1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_cmd_writer.sv
// Bench for adc_cmd_writer: directed scenarios plus random bursts, checked
// against a word queue and SPI frame timing rules.
module tb_adc_cmd_writer;
    localparam int W          = 8;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CS_GAP     = 2;
    localparam int LIM        = 5000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready, sclk, sdo, cs_n, busy, done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q [$];

    int   low_len = 0, hi_len = 0, rises = 0, last_rises = 0, last_gap = 0;
    int   frames = 0, done_cnt = 0, nbits = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, seen_frame = 1'b0;
    logic first_pending = 1'b0, last_first = 1'b0;
    logic [W-1:0] acc = '0;

    adc_cmd_writer #(
        .WORD_W     (W),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CS_GAP     (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .sclk     (sclk),
        .sdo      (sdo),
        .cs_n     (cs_n),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Link observer: rebuilds words from sclk rising edges and checks frame timing
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs    = 1'b1;
            prev_sclk  = 1'b0;
            seen_frame = 1'b0;
            nbits      = 0;
            rises      = 0;
            low_len    = 0;
            hi_len     = 0;
        end else begin
            if (prev_cs && !cs_n) begin
                if (seen_frame) begin
                    last_gap = hi_len;
                    check("cs_high_gap", hi_len >= CLK_DIV, 1);
                end
                seen_frame    = 1'b1;
                low_len       = 0;
                rises         = 0;
                nbits         = 0;
                first_pending = 1'b1;
            end
            if (!prev_cs && cs_n) begin
                check("frame_len", low_len, 2*CLK_DIV*rises + CS_GAP*CLK_DIV);
                check("frame_whole_words", rises % W, 0);
                check("done_at_release", done, 1);
                check("sdo_idle_at_release", sdo, 0);
                check("sclk_idle_at_release", sclk, 0);
                last_rises = rises;
                frames++;
                hi_len = 0;
            end else if (done) begin
                check("done_only_at_release", done, 0);
            end
            if (done) done_cnt++;
            if (!prev_sclk && sclk) begin
                check("sclk_rise_in_frame", cs_n, 0);
                rises++;
`ifdef ADC_WR_LSB_FIRST_EN
                acc = {sdo, acc[W-1:1]};
`else
                acc = {acc[W-2:0], sdo};
`endif
                if (first_pending) begin
                    last_first    = sdo;
                    first_pending = 1'b0;
                end
                nbits++;
                if (nbits == W) begin
                    nbits = 0;
                    if (exp_q.size() > 0) check("word", acc, exp_q.pop_front());
                    else check("word_queue_nonempty", exp_q.size(), 1);
                end
            end
            if (!cs_n) low_len++;
            else hi_len++;
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end
    end

    task automatic put(input logic [W-1:0] d, output int waited);
        wr_data  = d;
        wr_valid = 1'b1;
        waited   = 0;
        while (!wr_ready && waited < LIM) begin
            @(negedge clk);
            waited++;
        end
        if (waited < LIM) exp_q.push_back(d);
        else check("put_timeout", waited, 0);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("done_within_limit", n < LIM, 1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_limit", n < LIM, 1);
        @(negedge clk);
    endtask

    initial begin
        int n, waited, d0, f0, nb;
        logic [W-1:0] w;
        logic exp_first;

        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_sdo", sdo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr_ready", wr_ready, 1);

        // single word, cs_n latency and frame length
        d0 = done_cnt;
        put(8'hA5, waited);
        n = 0;
        while (cs_n && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("t1_cs_fall_latency", n, 2);
        wait_done();
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_busy_after", busy, 0);
        check("t1_rises", last_rises, W);

        // two words back to back in one frame
        repeat (4) @(negedge clk);
        d0 = done_cnt; f0 = frames;
        put(8'h12, waited);
        put(8'h34, waited);
        check("t2_second_accept_wait", waited, 0);
        wait_done();
        check("t2_frames", frames - f0, 1);
        check("t2_done_count", done_cnt - d0, 1);
        check("t2_rises", last_rises, 2*W);

        // FIFO fills, sixth word held until the next pop
        repeat (4) @(negedge clk);
        f0 = frames;
        for (int k = 0; k < 5; k++) begin
            put(W'(k), waited);
            check("t3_accept_wait", waited, 0);
        end
        check("t3_ready_low_when_full", wr_ready, 0);
        put(W'(5), waited);
        check("t3_word5_wait", waited, (2*W*CLK_DIV + 3) - 5);
        wait_done();
        check("t3_frames", frames - f0, 1);
        check("t3_rises", last_rises, 6*W);

        // asynchronous reset in the middle of the second bit
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        put(8'hC3, waited);
        n = 0;
        while (!(rises == 1 && !sclk && !cs_n) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_bit2", n < LIM, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_cs_n", cs_n, 1);
        check("t4_async_sclk", sclk, 0);
        check("t4_async_sdo", sdo, 0);
        check("t4_async_done", done, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t4_wr_ready_after", wr_ready, 1);
        @(negedge clk);
        check("t4_no_done", done_cnt - d0, 0);
        put(8'h0F, waited);
        wait_done();
        check("t4_rises_after", last_rises, W);

        // first bit reflects the serialization order
        repeat (4) @(negedge clk);
        w = 8'h01;
`ifdef ADC_WR_LSB_FIRST_EN
        exp_first = w[0];
`else
        exp_first = w[W-1];
`endif
        put(w, waited);
        wait_done();
        check("t5_first_bit", last_first, exp_first);

        // new frame right after done keeps cs_n high a while
        put(8'hFF, waited);
        wait_done();
        check("t6_cs_high_gap", last_gap >= 2, 1);
        check("t6_rises", last_rises, W);

        // random bursts with random pauses
        for (int it = 0; it < 25; it++) begin
            nb = int'($urandom_range(1, 6));
            for (int j = 0; j < nb; j++) begin
                w = W'($urandom);
                put(w, waited);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
            end
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_done_eq_frames", done_cnt, frames);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
